task_dispatcher: RTL and testbench

- Consumes the flattened environment task memory (TASK_MEM_DEPTH entries × INSN_COUNT words × INSN_SIZE bits) and walks it entry by entry.
- Decodes control entries, which select a target core mask, and program entries, which are instruction blocks.
- Streams each program's words over a valid/ready handshake to the selected cores, after those cores report idle.
- Sits between the task-memory source and the per-core instruction loaders.

---
 rtl/task_dispatcher.sv | 141 ++++++++++++++
 tb/tb_task_dispatcher.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : task_dispatcher
// Purpose  : Walks the environment task memory, tracks the core mask set by
//            control entries, and streams program words to the masked cores.
// Revision : 1.0
// ============================================================================
module task_dispatcher #(
   parameter int TASK_MEM_DEPTH = 8,
   parameter int INSN_COUNT     = 16,
   parameter int INSN_SIZE      = 16,
   parameter int CORES_NUM      = 4
) (
   input  logic                                           clk,
   input  logic                                           reset_n,
   input  logic [TASK_MEM_DEPTH*INSN_COUNT*INSN_SIZE-1:0] env_task_memory,
   input  logic                                           start,
   input  logic [CORES_NUM-1:0]                           core_idle,
   input  logic                                           insn_ready,
   output logic                                           insn_valid,
   output logic [INSN_SIZE-1:0]                           insn_data,
   output logic [CORES_NUM-1:0]                           insn_core_mask,
   output logic                                           insn_last,
   output logic [$clog2(TASK_MEM_DEPTH)-1:0]              cur_entry,
   output logic                                           busy,
   output logic                                           done,
   output logic                                           error
);

   localparam int PTR_W  = $clog2(TASK_MEM_DEPTH);
   localparam int WIDX_W = $clog2(INSN_COUNT);
   localparam logic [PTR_W-1:0]     C_LAST_PTR  = PTR_W'(TASK_MEM_DEPTH - 1);
   localparam logic [WIDX_W-1:0]    C_LAST_WIDX = WIDX_W'(INSN_COUNT - 1);
   localparam logic [INSN_SIZE-1:0] C_CTRL_TAG  = '1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DECODE    = 3'd1,
      S_WAIT_IDLE = 3'd2,
      S_SEND      = 3'd3,
      S_DONE      = 3'd4,
      S_ERR       = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [CORES_NUM-1:0]  mask_q, mask_d;
   logic [WIDX_W-1:0]     widx_q, widx_d;

   logic [INSN_SIZE-1:0]  w_mem [TASK_MEM_DEPTH][INSN_COUNT];
   logic [INSN_SIZE-1:0]  w_w0, w_w1, w_word;
   logic                  w_empty, w_ctrl, w_last, w_cores_idle;

   for (genvar e = 0; e < TASK_MEM_DEPTH; e++) begin : g_entry
      for (genvar k = 0; k < INSN_COUNT; k++) begin : g_word
         assign w_mem[e][k] = env_task_memory[(e*INSN_COUNT+k)*INSN_SIZE +: INSN_SIZE];
      end
   end

   assign w_w0         = w_mem[ptr_q][0];
   assign w_w1         = w_mem[ptr_q][1];
   assign w_word       = w_mem[ptr_q][widx_q];
   assign w_empty      = (w_w0 == '0) && (w_w1 == '0);
   assign w_ctrl       = (w_w1 == C_CTRL_TAG);
   // An F opcode ends the program early; otherwise the entry's last word does.
   assign w_last       = (w_word[INSN_SIZE-1 -: 4] == 4'hF) || (widx_q == C_LAST_WIDX);
   assign w_cores_idle = ((core_idle & mask_q) == mask_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         mask_q  <= '0;
         widx_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mask_q  <= mask_d;
         widx_q  <= widx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mask_d  = mask_q;
      widx_d  = widx_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               ptr_d   = '0;
               mask_d  = '0;
               widx_d  = '0;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_empty) begin
               state_d = S_DONE;
            end else if (w_ctrl) begin
               mask_d = w_w0[CORES_NUM-1:0];
               if (ptr_q == C_LAST_PTR) state_d = S_DONE;
               else                     ptr_d   = ptr_q + PTR_W'(1);
            end else if (mask_q == '0) begin
               state_d = S_ERR;
            end else begin
               widx_d  = '0;
               state_d = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (w_cores_idle) state_d = S_SEND;
         end
         S_SEND: begin
            if (insn_ready) begin
               if (!w_last) begin
                  widx_d = widx_q + WIDX_W'(1);
               end else if (ptr_q == C_LAST_PTR) begin
                  state_d = S_DONE;
               end else begin
                  ptr_d   = ptr_q + PTR_W'(1);
                  state_d = S_DECODE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Word outputs are forced to zero outside SEND so reset leaves nothing visible.
   assign insn_valid     = (state_q == S_SEND);
   assign insn_data      = insn_valid ? w_word : '0;
   assign insn_core_mask = insn_valid ? mask_q : '0;
   assign insn_last      = insn_valid & w_last;
   assign cur_entry      = ptr_q;
   assign busy           = (state_q == S_DECODE) || (state_q == S_WAIT_IDLE) || (state_q == S_SEND);
   assign done           = (state_q == S_DONE);
   assign error          = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_task_dispatcher
// Purpose  : Directed, table-driven checks of task_dispatcher.
// Revision : 1.0
// ============================================================================
module tb_task_dispatcher;
   localparam int D  = 8;
   localparam int IC = 16;
   localparam int IS = 16;
   localparam int CN = 4;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [D*IC*IS-1:0]  mem;
   logic                start;
   logic [CN-1:0]       core_idle;
   logic                insn_ready;
   logic                insn_valid;
   logic [IS-1:0]       insn_data;
   logic [CN-1:0]       insn_core_mask;
   logic                insn_last;
   logic [2:0]          cur_entry;
   logic                busy, done, error;

   int checks = 0;
   int errors = 0;

   task_dispatcher #(
      .TASK_MEM_DEPTH(D), .INSN_COUNT(IC), .INSN_SIZE(IS), .CORES_NUM(CN)
   ) dut (
      .clk(clk), .reset_n(reset_n), .env_task_memory(mem), .start(start),
      .core_idle(core_idle), .insn_ready(insn_ready), .insn_valid(insn_valid),
      .insn_data(insn_data), .insn_core_mask(insn_core_mask), .insn_last(insn_last),
      .cur_entry(cur_entry), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic [3:0]  idle;
      logic        ready;
      logic        valid;
      logic [15:0] data;
      logic [3:0]  mask;
      logic        last;
      logic        busy;
      logic        done;
      logic        err;
      logic [2:0]  entry;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic s, logic [3:0] id, logic r, logic v, logic [15:0] d,
                               logic [3:0] m, logic l, logic b, logic dn, logic e, logic [2:0] en);
      vec_t t;
      t.start = s; t.idle = id; t.ready = r; t.valid = v; t.data = d; t.mask = m;
      t.last = l; t.busy = b; t.done = dn; t.err = e; t.entry = en;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int e, input int k, input logic [15:0] v);
      mem[(e*IC+k)*IS +: IS] = v;
   endtask

   task automatic load_basic();
      mem = '0;
      set_word(0, 0, 16'h0002); set_word(0, 1, 16'hFFFF);
      set_word(1, 0, 16'hC008); set_word(1, 1, 16'hC041);
      set_word(1, 2, 16'h3182); set_word(1, 3, 16'hF000);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, insn_valid, 0);
      chk({tag, "_data"},  insn_data, 0);
      chk({tag, "_mask"},  insn_core_mask, 0);
      chk({tag, "_last"},  insn_last, 0);
      chk({tag, "_entry"}, cur_entry, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_error"}, error, 0);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!insn_valid && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_valid_timeout"}, insn_valid, 1);
   endtask

   // Expects the stream to be presenting word 0; consumes all words with ready=1.
   task automatic expect_stream(input string tag, input logic [2:0] entry,
                                input logic [3:0] mask, input logic [15:0] w[$]);
      for (int i = 0; i < w.size(); i++) begin
         chk($sformatf("%s_valid%0d", tag, i), insn_valid, 1);
         chk($sformatf("%s_data%0d", tag, i), insn_data, w[i]);
         chk($sformatf("%s_mask%0d", tag, i), insn_core_mask, mask);
         chk($sformatf("%s_last%0d", tag, i), insn_last, (i == w.size() - 1));
         chk($sformatf("%s_entry%0d", tag, i), cur_entry, entry);
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ws[$];
      reset_n = 1'b0; start = 1'b0; core_idle = 4'hF; insn_ready = 1'b1; mem = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // Basic dispatch (with a start during SEND), then a backpressured rerun.
      load_basic();
      vecs.push_back(mk(1, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 3'd0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 1, 16'hC008, 4'h2, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 1, 16'hC041, 4'h2, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(1, 4'hF, 1, 1, 16'h3182, 4'h2, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 1, 16'hF000, 4'h2, 1, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 3'd2));
      vecs.push_back(mk(0, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 0, 1, 0, 3'd2));
      vecs.push_back(mk(0, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 0, 1, 0, 3'd2));
      vecs.push_back(mk(1, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 3'd0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 1, 16'hC008, 4'h2, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 1, 16'hC041, 4'h2, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 0, 1, 16'hC041, 4'h2, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 0, 1, 16'hC041, 4'h2, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 0, 1, 16'hC041, 4'h2, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 1, 16'h3182, 4'h2, 0, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 1, 16'hF000, 4'h2, 1, 1, 0, 0, 3'd1));
      vecs.push_back(mk(0, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 1, 0, 0, 3'd2));
      vecs.push_back(mk(0, 4'hF, 1, 0, 16'h0000, 4'h0, 0, 0, 1, 0, 3'd2));

      for (int i = 0; i < vecs.size(); i++) begin
         start = vecs[i].start; core_idle = vecs[i].idle; insn_ready = vecs[i].ready;
         tick();
         chk($sformatf("tbl%0d_valid", i), insn_valid, vecs[i].valid);
         chk($sformatf("tbl%0d_busy", i),  busy,       vecs[i].busy);
         chk($sformatf("tbl%0d_done", i),  done,       vecs[i].done);
         chk($sformatf("tbl%0d_error", i), error,      vecs[i].err);
         chk($sformatf("tbl%0d_entry", i), cur_entry,  vecs[i].entry);
         if (vecs[i].valid) begin
            chk($sformatf("tbl%0d_data", i), insn_data,      vecs[i].data);
            chk($sformatf("tbl%0d_mask", i), insn_core_mask, vecs[i].mask);
            chk($sformatf("tbl%0d_last", i), insn_last,      vecs[i].last);
         end
      end
      start = 1'b0; insn_ready = 1'b1; core_idle = 4'hF;

      // Idle barrier: only core 0 matters, and it is held busy for 5 cycles.
      mem = '0;
      set_word(0, 0, 16'h0001); set_word(0, 1, 16'hFFFF);
      set_word(1, 0, 16'h1234); set_word(1, 1, 16'hF001);
      core_idle = 4'b1110;
      pulse_start();
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("barrier_valid%0d", i), insn_valid, 0);
         chk($sformatf("barrier_busy%0d", i), busy, 1);
      end
      core_idle = 4'b1111;
      tick();
      ws = '{16'h1234, 16'hF001};
      expect_stream("barrier", 3'd1, 4'h1, ws);
      tick();
      chk("barrier_done", done, 1);

      // Full-length program, then a second program reusing the same mask.
      mem = '0;
      set_word(0, 0, 16'h000C); set_word(0, 1, 16'hFFFF);
      for (int k = 0; k < IC; k++) set_word(1, k, 16'h1000 + 16'(k));
      set_word(2, 0, 16'h2000); set_word(2, 1, 16'h2001); set_word(2, 2, 16'hF002);
      pulse_start();
      wait_valid("full", 10);
      ws = {};
      for (int k = 0; k < IC; k++) ws.push_back(16'h1000 + 16'(k));
      expect_stream("full", 3'd1, 4'hC, ws);
      wait_valid("persist", 10);
      ws = '{16'h2000, 16'h2001, 16'hF002};
      expect_stream("persist", 3'd2, 4'hC, ws);
      tick();
      chk("persist_done", done, 1);
      chk("persist_entry", cur_entry, 3);

      // Program with no mask selected, then recovery with corrected memory.
      mem = '0;
      set_word(0, 0, 16'h4300);
      pulse_start();
      chk("err_valid_decode", insn_valid, 0);
      tick();
      chk("err_error", error, 1);
      chk("err_entry", cur_entry, 0);
      chk("err_valid", insn_valid, 0);
      chk("err_busy", busy, 0);
      tick();
      chk("err_sticky", error, 1);
      load_basic();
      pulse_start();
      chk("recover_error", error, 0);
      chk("recover_busy", busy, 1);
      wait_valid("recover", 10);
      ws = '{16'hC008, 16'hC041, 16'h3182, 16'hF000};
      expect_stream("recover", 3'd1, 4'h2, ws);
      tick();
      chk("recover_done", done, 1);

      // Asynchronous reset in the middle of SEND.
      pulse_start();
      wait_valid("rst", 10);
      tick();
      chk("rst_pre_data", insn_data, 16'hC041);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("rst_async");
      #2 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rst_after_valid%0d", i), insn_valid, 0);
         chk($sformatf("rst_after_busy%0d", i), busy, 0);
      end

      // Program in the last entry: must finish without wrapping to entry 0.
      mem = '0;
      for (int e = 0; e < D - 1; e++) begin
         set_word(e, 0, 16'h0003); set_word(e, 1, 16'hFFFF);
      end
      set_word(D - 1, 0, 16'hABCD); set_word(D - 1, 1, 16'hF00E);
      pulse_start();
      wait_valid("eom", 20);
      ws = '{16'hABCD, 16'hF00E};
      expect_stream("eom", 3'd7, 4'h3, ws);
      chk("eom_done", done, 1);
      chk("eom_entry", cur_entry, 7);
      tick();
      tick();
      chk("eom_valid_after", insn_valid, 0);
      chk("eom_entry_after", cur_entry, 7);
      chk("eom_busy_after", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
